main_mem: RTL and testbench

MAIN_MEM -- requirements
Module: main_mem

---
 rtl/main_mem.sv | 116 +++++++++++
 tb/tb_main_mem.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/main_mem.sv
// Line-oriented main memory behind a cache: fixed-latency read/write FSM, write priority.
// Optional completed-access statistics enabled by defining MAIN_MEM_STAT_EN.
module main_mem #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int MEM_ADDR_LEN  = 10,
    parameter int LATENCY       = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               mem_rd_req,
    input  logic                               mem_wr_req,
    input  logic [MEM_ADDR_LEN-1:0]            mem_addr,
    input  logic [32*(2**LINE_ADDR_LEN)-1:0]   mem_wr_line,
    output logic [32*(2**LINE_ADDR_LEN)-1:0]   mem_rd_line,
    output logic                               mem_gnt,
    output logic [31:0]                        rd_count,
    output logic [31:0]                        wr_count
);

    localparam int LINE_W = 32 * (2**LINE_ADDR_LEN);
    localparam int DEPTH  = 2**MEM_ADDR_LEN;
    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                    state;
    logic [7:0]                cnt;
    logic                      op_wr;
    logic [MEM_ADDR_LEN-1:0]   addr_q;
    logic [LINE_W-1:0]         line_q;
    logic [LINE_W-1:0]         mem [DEPTH];
    logic                      done_edge;

    // Asserted during the last BUSY cycle; the following edge completes the access.
    assign done_edge = (state == BUSY) && (cnt == 8'd0);

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            mem_gnt     <= 1'b0;
            mem_rd_line <= '0;
            op_wr       <= 1'b0;
            addr_q      <= '0;
            line_q      <= '0;
        end else begin
            mem_gnt <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_wr_req) begin
                        state  <= BUSY;
                        op_wr  <= 1'b1;
                        addr_q <= mem_addr;
                        line_q <= mem_wr_line;
                        cnt    <= LAT_M1;
                    end else if (mem_rd_req) begin
                        state  <= BUSY;
                        op_wr  <= 1'b0;
                        addr_q <= mem_addr;
                        cnt    <= LAT_M1;
                    end
                end
                BUSY: begin
                    if (cnt == 8'd0) begin
                        state   <= DONE;
                        mem_gnt <= 1'b1;
                        if (!op_wr) begin
                            mem_rd_line <= mem[addr_q];
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // NOTE: the array has no reset; contents survive rst. An aborted write never
    // lands because reset forces the FSM out of BUSY before the completing edge.
    always_ff @(posedge clk) begin
        if (done_edge && op_wr) begin
            mem[addr_q] <= line_q;
        end
    end

`ifdef MAIN_MEM_STAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count <= 32'd0;
            wr_count <= 32'd0;
        end else if (done_edge) begin
            if (op_wr) begin
                wr_count <= wr_count + 32'd1;
            end else begin
                rd_count <= rd_count + 32'd1;
            end
        end
    end
`else
    assign rd_count = 32'd0;
    assign wr_count = 32'd0;
`endif

endmodule

// File: tb/tb_main_mem.sv
// Scoreboard bench for main_mem: driver pushes expected grants, monitor pops on mem_gnt.
// Honours MAIN_MEM_STAT_EN for the expected statistics counters.
module tb_main_mem;

    localparam int LA  = 3;
    localparam int MA  = 10;
    localparam int LAT = 4;
    localparam int LW  = 32 << LA;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_rd_req;
    logic          mem_wr_req;
    logic [MA-1:0] mem_addr;
    logic [LW-1:0] mem_wr_line;
    logic [LW-1:0] mem_rd_line;
    logic          mem_gnt;
    logic [31:0]   rd_count;
    logic [31:0]   wr_count;

    main_mem #(.LINE_ADDR_LEN(LA), .MEM_ADDR_LEN(MA), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_rd_req (mem_rd_req),
        .mem_wr_req (mem_wr_req),
        .mem_addr   (mem_addr),
        .mem_wr_line(mem_wr_line),
        .mem_rd_line(mem_rd_line),
        .mem_gnt    (mem_gnt),
        .rd_count   (rd_count),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit            is_rd;
        logic [MA-1:0] addr;
        logic [LW-1:0] line;   // read: expected data; write: expected held mem_rd_line
        int            due;    // posedge number at which mem_gnt must rise
    } exp_t;

    exp_t          sbq[$];
    logic [LW-1:0] model [logic [MA-1:0]];
    logic [MA-1:0] waddrs[$];
    logic [LW-1:0] last_rd = '0;
    int            mon_rd = 0;
    int            mon_wr = 0;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    function automatic int exp_rc();
`ifdef MAIN_MEM_STAT_EN
        return mon_rd;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_wc();
`ifdef MAIN_MEM_STAT_EN
        return mon_wr;
`else
        return 0;
`endif
    endfunction

    // Monitor: every grant must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst === 1'b0 && mem_gnt === 1'b1) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_gnt @cyc %0d: got 1 want 0", cyc);
            end else begin
                e = sbq.pop_front();
                check("gnt_time", LW'(cyc), LW'(e.due));
                if (e.is_rd) begin
                    mon_rd++;
                    check("rd_line", mem_rd_line, e.line);
                end else begin
                    mon_wr++;
                    check("rd_line_hold", mem_rd_line, e.line);
                end
                check("rd_count", LW'(rd_count), LW'(exp_rc()));
                check("wr_count", LW'(wr_count), LW'(exp_wc()));
            end
        end
    end

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int i = 0; i < (LW / 32); i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    function automatic void note_write(input logic [MA-1:0] a, input logic [LW-1:0] l);
        if (!model.exists(a)) waddrs.push_back(a);
        model[a] = l;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic do_access(input bit wr, input bit rd, input logic [MA-1:0] a,
                             input logic [LW-1:0] l);
        int   sample;
        int   pending;
        int   t;
        exp_t e;
        mem_wr_req  = wr;
        mem_rd_req  = rd;
        mem_addr    = a;
        mem_wr_line = l;
        sample      = cyc + 1;
        pending     = int'(wr) + int'(rd);
        if (wr) begin
            e = '{is_rd: 1'b0, addr: a, line: last_rd, due: sample + LAT};
            sbq.push_back(e);
            note_write(a, l);
        end
        if (rd) begin
            e = '{is_rd: 1'b1, addr: a, line: model[a],
                  due: sample + (wr ? 2 * LAT + 2 : LAT)};
            sbq.push_back(e);
            last_rd = model[a];
        end
        t = 0;
        while (pending > 0) begin
            @(negedge clk);
            t++;
            if (t > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL gnt_timeout @cyc %0d: got no grant want grant", cyc);
                mem_wr_req = 1'b0;
                mem_rd_req = 1'b0;
                sbq.delete();
                pending = 0;
            end else if (mem_gnt === 1'b1) begin
                pending--;
                if (mem_wr_req) mem_wr_req = 1'b0;
                else            mem_rd_req = 1'b0;
            end else if (!(wr && rd)) begin
                // Inputs wander while the access is in flight; only the latched values count.
                mem_addr    = MA'($urandom);
                mem_wr_line = rand_line();
            end
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst        = 1'b1;
        mem_rd_req = 1'b0;
        mem_wr_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b0;
        last_rd = '0;
        mon_rd  = 0;
        mon_wr  = 0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rd_line"}, mem_rd_line, last_rd);
        check({tag, "_rd_count"}, LW'(rd_count), LW'(exp_rc()));
        check({tag, "_wr_count"}, LW'(wr_count), LW'(exp_wc()));
    endtask

    initial begin
        logic [LW-1:0] l;
        logic [MA-1:0] a;
        int            op;
        mem_addr    = '0;
        mem_wr_line = '0;
        apply_reset();

        // Idle after reset: no grants, zeroed outputs.
        for (int i = 0; i < 10; i++) begin
            check("idle_gnt", LW'(mem_gnt), '0);
            @(negedge clk);
        end
        check_idle("reset");

        // Write then read the same line.
        for (int i = 0; i < (LW / 32); i++) l[32*i +: 32] = 32'h1000 + 32'(i);
        do_access(1'b1, 1'b0, MA'(10'h005), l);
        do_access(1'b0, 1'b1, MA'(10'h005), '0);

        // Simultaneous write and read at the top address: write wins, read follows.
        do_access(1'b1, 1'b1, MA'(10'h3FF), rand_line());

        // Reset in the middle of a write must leave the old contents.
        do_access(1'b1, 1'b0, MA'(10'h007), '0);
        mem_wr_req  = 1'b1;
        mem_addr    = MA'(10'h007);
        mem_wr_line = rand_line();
        @(negedge clk);
        @(negedge clk);
        apply_reset();
        check_idle("abort");
        for (int i = 0; i < LAT + 4; i++) @(negedge clk);
        do_access(1'b0, 1'b1, MA'(10'h007), '0);

        // Counter scenario: 3 reads, 2 writes after a fresh reset.
        apply_reset();
        do_access(1'b1, 1'b0, MA'(10'h010), rand_line());
        do_access(1'b0, 1'b1, MA'(10'h010), '0);
        do_access(1'b1, 1'b0, MA'(10'h011), rand_line());
        do_access(1'b0, 1'b1, MA'(10'h011), '0);
        do_access(1'b0, 1'b1, MA'(10'h005), '0);
        check_idle("stats");

        // Randomised traffic over a small address window to force reuse.
        for (int n = 0; n < 40; n++) begin
            op = int'($urandom_range(0, 3));
            a  = ($urandom_range(0, 7) == 0) ? MA'(10'h3FF) : MA'($urandom_range(0, 31));
            if (op == 0) begin
                do_access(1'b1, 1'b1, a, rand_line());
            end else if (op == 1) begin
                do_access(1'b1, 1'b0, a, rand_line());
            end else begin
                a = waddrs[$urandom_range(0, waddrs.size() - 1)];
                do_access(1'b0, 1'b1, a, '0);
            end
        end
        check_idle("final");
        check("sb_empty", LW'(sbq.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
